// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the cache-pair AXI arbiter: read/write FSM state
// encodings, grant identifiers, MMIO address map constants and the MMIO
// address classifier used to flag device accesses for difftest skipping.
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_ADDR = 2'd1,
    R_DATA = 2'd2
  } read_state_t;

  typedef enum logic [1:0] {
    W_IDLE   = 2'd0,
    W_ACTIVE = 2'd1,
    W_RESP   = 2'd2
  } write_state_t;

  // Requester identifiers as stored in the round-robin last-grant bit.
  localparam logic GRANT_ICACHE = 1'b0;
  localparam logic GRANT_DCACHE = 1'b1;

  // Width of the constant-zero AXI ID fields on the SoC side.
  localparam int ID_W = 4;

  localparam logic [3:0]  MMIO_HI_NIBBLE = 4'h1;
  localparam logic [31:0] VGA_BASE       = 32'h2100_0000;
  localparam logic [31:0] VGA_END        = 32'h2112_C000;

  // Device space: the whole 0x1xxx_xxxx window plus the VGA framebuffer.
  function automatic logic is_mmio(input logic [31:0] addr);
    return (addr[31:28] == MMIO_HI_NIBBLE) ||
           ((addr >= VGA_BASE) && (addr < VGA_END));
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_rr_arb2.sv
// rr_arb2: two-requester round-robin arbiter.
//   clock, rst_n : clock and asynchronous active-low reset
//   req[1:0]     : request vector, bit 0 = icache, bit 1 = dcache
//   enable       : load the current pick into the owner register
//   pick         : combinational winner for the current request vector
//   owner        : registered grant; doubles as the last-grant bit
// Resets to "dcache granted last" so the icache wins the first tie.
module rr_arb2
  import mem_bus_arbiter_pkg::*;
(
  input  logic       clock,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       enable,
  output logic       pick,
  output logic       owner
);

  always_comb begin
    case (req)
      2'b01:   pick = GRANT_ICACHE;
      2'b10:   pick = GRANT_DCACHE;
      2'b11:   pick = ~owner;          // whoever was not served last
      default: pick = owner;
    endcase
  end

  // NOTE: clocked state is written with non-blocking assignments so every
  // register samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      owner <= GRANT_DCACHE;
    end else if (enable) begin
      owner <= pick;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one AXI4 master port between the icache (read
// only) and the dcache (read and write).
//   clock, rst_n     : clock and asynchronous active-low reset
//   icache_ar*/r*    : icache read address / read data channels
//   dcache_ar*/r*    : dcache read address / read data channels
//   dcache_aw*/w*/b* : dcache write address / data / response channels
//   m_*              : SoC-side AXI master port (IDs tied to zero)
//   ls_execute_ready : LSU execute-ready, clears mmio_pending
//   mmio_pending     : an MMIO AR/AW handshake happened and is unretired
// Reads are round-robin arbitrated; writes belong to the dcache. A dcache
// read is held off while a write is in flight, and a write does not start
// while the read side holds a dcache grant. Payloads are muxed, not
// registered; requesters keep them stable until ready.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
) (
  input  logic                clock,
  input  logic                rst_n,
  // icache read
  input  logic                icache_arvalid,
  output logic                icache_arready,
  input  logic [ADDR_W-1:0]   icache_araddr,
  input  logic [7:0]          icache_arlen,
  input  logic [2:0]          icache_arsize,
  input  logic [1:0]          icache_arburst,
  output logic                icache_rvalid,
  input  logic                icache_rready,
  output logic [DATA_W-1:0]   icache_rdata,
  output logic [1:0]          icache_rresp,
  output logic                icache_rlast,
  // dcache read
  input  logic                dcache_arvalid,
  output logic                dcache_arready,
  input  logic [ADDR_W-1:0]   dcache_araddr,
  input  logic [7:0]          dcache_arlen,
  input  logic [2:0]          dcache_arsize,
  input  logic [1:0]          dcache_arburst,
  output logic                dcache_rvalid,
  input  logic                dcache_rready,
  output logic [DATA_W-1:0]   dcache_rdata,
  output logic [1:0]          dcache_rresp,
  output logic                dcache_rlast,
  // dcache write
  input  logic                dcache_awvalid,
  output logic                dcache_awready,
  input  logic [ADDR_W-1:0]   dcache_awaddr,
  input  logic [7:0]          dcache_awlen,
  input  logic [2:0]          dcache_awsize,
  input  logic [1:0]          dcache_awburst,
  input  logic                dcache_wvalid,
  output logic                dcache_wready,
  input  logic [DATA_W-1:0]   dcache_wdata,
  input  logic [DATA_W/8-1:0] dcache_wstrb,
  input  logic                dcache_wlast,
  output logic                dcache_bvalid,
  input  logic                dcache_bready,
  output logic [1:0]          dcache_bresp,
  // SoC master port
  output logic                m_arvalid,
  input  logic                m_arready,
  output logic [ID_W-1:0]     m_arid,
  output logic [ADDR_W-1:0]   m_araddr,
  output logic [7:0]          m_arlen,
  output logic [2:0]          m_arsize,
  output logic [1:0]          m_arburst,
  input  logic                m_rvalid,
  output logic                m_rready,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic [1:0]          m_rresp,
  input  logic                m_rlast,
  output logic                m_awvalid,
  input  logic                m_awready,
  output logic [ID_W-1:0]     m_awid,
  output logic [ADDR_W-1:0]   m_awaddr,
  output logic [7:0]          m_awlen,
  output logic [2:0]          m_awsize,
  output logic [1:0]          m_awburst,
  output logic                m_wvalid,
  input  logic                m_wready,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  output logic                m_wlast,
  input  logic                m_bvalid,
  output logic                m_bready,
  input  logic [1:0]          m_bresp,
  // LSU / difftest
  input  logic                ls_execute_ready,
  output logic                mmio_pending
);

  read_state_t  r_state, r_next;
  write_state_t w_state;
  logic         aw_done, w_done;

  logic [1:0] r_req;
  logic       r_grant_en, r_pick, r_owner;
  logic       r_addr_st, r_data_st, w_active, w_resp;
  logic       owner_dc;
  logic       aw_done_nx, w_done_nx, w_start;
  logic       ar_hs, aw_hs, r_last_hs, mmio_set;

  assign r_addr_st = (r_state == R_ADDR);
  assign r_data_st = (r_state == R_DATA);
  assign w_active  = (w_state == W_ACTIVE);
  assign w_resp    = (w_state == W_RESP);
  assign owner_dc  = (r_owner == GRANT_DCACHE);

  // ---------------- read side ----------------
  // The dcache may not win a read while its own write is outstanding.
  assign r_req      = {dcache_arvalid && (w_state == W_IDLE), icache_arvalid};
  assign r_grant_en = (r_state == R_IDLE) && (|r_req);

  rr_arb2 u_rr_arb2 (
    .clock  (clock),
    .rst_n  (rst_n),
    .req    (r_req),
    .enable (r_grant_en),
    .pick   (r_pick),
    .owner  (r_owner)
  );

  assign m_arvalid = r_addr_st;
  assign m_arid    = '0;
  assign m_araddr  = owner_dc ? dcache_araddr  : icache_araddr;
  assign m_arlen   = owner_dc ? dcache_arlen   : icache_arlen;
  assign m_arsize  = owner_dc ? dcache_arsize  : icache_arsize;
  assign m_arburst = owner_dc ? dcache_arburst : icache_arburst;

  assign icache_arready = r_addr_st && !owner_dc && m_arready;
  assign dcache_arready = r_addr_st &&  owner_dc && m_arready;

  assign icache_rvalid = r_data_st && !owner_dc && m_rvalid;
  assign dcache_rvalid = r_data_st &&  owner_dc && m_rvalid;
  assign m_rready      = r_data_st && (owner_dc ? dcache_rready : icache_rready);

  // Payload is shared; each requester qualifies it with its own rvalid.
  assign icache_rdata = m_rdata;
  assign icache_rresp = m_rresp;
  assign icache_rlast = m_rlast;
  assign dcache_rdata = m_rdata;
  assign dcache_rresp = m_rresp;
  assign dcache_rlast = m_rlast;

  assign ar_hs     = m_arvalid && m_arready;
  assign r_last_hs = m_rvalid && m_rready && m_rlast;

  // NOTE: every always_comb output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (|r_req)    r_next = R_ADDR;
      R_ADDR:  if (ar_hs)     r_next = R_DATA;
      R_DATA:  if (r_last_hs) r_next = R_IDLE;
      default:                r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) r_state <= R_IDLE;
    else        r_state <= r_next;
  end

  // ---------------- write side ----------------
  // Hold off a new write while a dcache read is in flight (write-after-read).
  assign w_start = dcache_awvalid && !((r_state != R_IDLE) && owner_dc);

  assign m_awid    = '0;
  assign m_awaddr  = dcache_awaddr;
  assign m_awlen   = dcache_awlen;
  assign m_awsize  = dcache_awsize;
  assign m_awburst = dcache_awburst;
  assign m_wdata   = dcache_wdata;
  assign m_wstrb   = dcache_wstrb;
  assign m_wlast   = dcache_wlast;

  // Each half is closed off once done so AW and W finish independently.
  assign m_awvalid      = w_active && !aw_done && dcache_awvalid;
  assign dcache_awready = w_active && !aw_done && m_awready;
  assign m_wvalid       = w_active && !w_done && dcache_wvalid;
  assign dcache_wready  = w_active && !w_done && m_wready;

  assign dcache_bvalid = w_resp && m_bvalid;
  assign m_bready      = w_resp && dcache_bready;
  assign dcache_bresp  = m_bresp;

  assign aw_hs      = m_awvalid && m_awready;
  assign aw_done_nx = aw_done || aw_hs;
  assign w_done_nx  = w_done || (m_wvalid && m_wready && dcache_wlast);

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      w_state <= W_IDLE;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: if (w_start) w_state <= W_ACTIVE;
        W_ACTIVE: begin
          if (aw_done_nx && w_done_nx) begin
            w_state <= W_RESP;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
          end else begin
            aw_done <= aw_done_nx;
            w_done  <= w_done_nx;
          end
        end
        W_RESP: if (m_bvalid && m_bready) w_state <= W_IDLE;
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // ---------------- MMIO flag ----------------
  assign mmio_set = (ar_hs && is_mmio(m_araddr[31:0])) ||
                    (aw_hs && is_mmio(m_awaddr[31:0]));

  // A fresh MMIO handshake wins over a same-cycle retire.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n)                mmio_pending <= 1'b0;
    else if (mmio_set)         mmio_pending <= 1'b1;
    else if (ls_execute_ready) mmio_pending <= 1'b0;
  end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

- Shares the core's single AXI4 master port to the SoC between the instruction cache (read-only) and the data cache (read and write).
- Sits between the cache pair and the core's top-level AXI master.
- Read channel: round-robin arbitration. Write channel: owned by the dcache, with read/write ordering interlocks.
- Flags MMIO handshakes for the difftest skip logic. The flag is held until the LSU reports execute-ready.

## Interface
Parameters:
- ADDR_W, 32, AXI address width
- DATA_W, 64, AXI data width

Ports:
- clock  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- icache_arvalid/arready/araddr/arlen/arsize/arburst  in/out/in/in/in/in  1/1/ADDR_W/8/3/2  icache read address
- icache_rvalid/rready/rdata/rresp/rlast  out/in/out/out/out  1/1/DATA_W/2/1  icache read data
- dcache_ar*, dcache_r*  same as icache  same  dcache read channels
- dcache_awvalid/awready/awaddr/awlen/awsize/awburst  in/out/in/in/in/in  1/1/ADDR_W/8/3/2  dcache write address
- dcache_wvalid/wready/wdata/wstrb/wlast  in/out/in/in/in  1/1/DATA_W/DATA_W/8/1  dcache write data
- dcache_bvalid/bready/bresp  out/in/out  1/1/2  dcache write response
- m_ar*, m_r*, m_aw*, m_w*, m_b*  mirror direction  same widths  SoC-side master port; m_arid/m_awid driven 0
- ls_execute_ready  in  1  LSU execute-ready; clears the MMIO flag
- mmio_pending  out  1  MMIO access in flight; feeds the difftest skip register

## Operation
Read FSM, states R_IDLE, R_ADDR, R_DATA:
- R_IDLE → R_ADDR when any eligible read request is present.
- Grant rule:
  - One requester: it wins.
  - Both: the one not granted last wins.
  - The grant and the last-grant bit are registered on leaving R_IDLE.
- R_ADDR:
  - m_arvalid=1; m_ar* is muxed from the granted requester.
  - The granted requester's arready = m_arready; the other requester's arready = 0.
  - → R_DATA on m_ar handshake.
- R_DATA:
  - m_r* is routed to the granted requester only; the other requester sees rvalid=0; m_rready = granted requester's rready.
  - → R_IDLE on the handshake with m_rlast=1.
- The dcache is ineligible for the read grant while the write FSM is not in W_IDLE. This is read-after-write ordering for MMIO.

Write FSM, states W_IDLE, W_ACTIVE, W_RESP:
- W_IDLE → W_ACTIVE when dcache_awvalid=1 and the read FSM does not hold a dcache grant.
- W_ACTIVE:
  - m_awvalid is gated by an internal aw_done flag; m_wvalid is gated by w_done.
  - AW and W handshake independently, in any order or in the same cycle.
  - aw_done sets on the AW handshake; w_done sets on the W handshake with wlast=1.
  - → W_RESP when both flags are set (their set conditions may fire in the same cycle); the flags clear on exit.
- W_RESP: B is passed through; → W_IDLE on the B handshake.
- In W_IDLE, dcache_awready=dcache_wready=0 and m_awvalid=m_wvalid=0.

MMIO flag:
- is_mmio(addr) = (addr[31:28]==4'h1) or (0x2100_0000 ≤ addr < 0x2112_C000).
- mmio_pending sets on any m_ar or m_aw handshake whose address satisfies is_mmio.
- It clears on ls_execute_ready=1, but only when no new set occurs that cycle; set has priority.

## Timing
- Reset values: all valid/ready outputs 0; mmio_pending 0; FSMs in R_IDLE/W_IDLE; last-grant bit = dcache, so the icache wins the first tie.
- Read: the request is seen in R_IDLE at cycle N; m_arvalid is asserted at N+1. There is no combinational path from requester arvalid to m_arvalid.
- The R path is combinational in R_DATA, so there is no added data latency.
- Write: awvalid is seen at N; m_awvalid/m_wvalid are asserted at N+1.
- B path is combinational in W_RESP.
- Read and write transactions overlap freely, except under the dcache ordering interlock.
- Requesters hold AR/AW payloads stable until their ready is returned (AXI rule); the arbiter does not register payloads.
- If the slave never responds, the FSM stays in its current state; there is no timeout.
- An asynchronous reset mid-burst returns both FSMs to idle immediately and drops all valids. The slave must be reset concurrently.

## Structure
- The shared package holds:
  - read-state and write-state enums;
  - MMIO constants: MMIO_HI_NIBBLE=4'h1, VGA_BASE=32'h2100_0000, VGA_END=32'h2112_C000;
  - an is_mmio function.
- Sub-module rr_arb2: two-requester round-robin with a registered last-grant bit and grant-enable.
- Everything else stays flat in mem_bus_arbiter.

## Test plan
- Reset, then drive icache and dcache arvalid in the same cycle at 0x3000_0000/0x8000_0000 → icache granted first:
  - m_araddr=0x3000_0000 one cycle later;
  - the dcache is granted after the icache's rlast;
  - the next tie goes to the icache again.
- icache burst, arlen=3, with m_rvalid toggling every other cycle → exactly 4 beats reach the icache; dcache_rvalid stays 0; R_IDLE follows the 4th beat.
- dcache write to 0x8000_0100 with W preceding AW by 2 cycles → both handshakes complete; W_RESP; bresp=OKAY reaches the dcache; dcache_awready only after AW forwarding.
- dcache read issued while a write is in W_RESP → m_arvalid stays 0 until the B handshake; it rises the cycle after W_IDLE.
- dcache read at 0x1000_0005 (UART) → mmio_pending=1 the cycle after the AR handshake. It holds until ls_execute_ready. A simultaneous new MMIO AW handshake keeps it at 1.
- Assert rst_n low mid R_DATA → all valids 0 and mmio_pending 0 within the same cycle; after release, a fresh icache read completes normally.
